// File: rtl/game_round_arbiter.sv
// Best-of-N match controller sharing one counter between players A and B.
// Optional round time limit enabled by defining MATCH_TIMEOUT_EN.
module game_round_arbiter #(
    parameter int CNT_W         = 4,
    parameter int INIT_VALUE    = 0,
    parameter int ROUNDS_TO_WIN = 3,
    parameter int HOLD_CYCLES   = 4,
    parameter int ROUND_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             req_a,
    input  logic [1:0]       mode_a,
    input  logic             load_a,
    input  logic [CNT_W-1:0] value_a,
    input  logic             req_b,
    input  logic [1:0]       mode_b,
    input  logic             load_b,
    input  logic [CNT_W-1:0] value_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [1:0]       control,
    output logic             init,
    output logic [CNT_W-1:0] initial_value,
    input  logic             gameover,
    input  logic [1:0]       who,
    output logic [2:0]       score_a,
    output logic [2:0]       score_b,
    output logic             busy,
    output logic             match_done,
`ifdef MATCH_TIMEOUT_EN
    output logic             timeout_pulse,
`endif
    output logic [1:0]       match_winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SCORE,
        S_HOLD,
        S_DONE
    } state_e;

    typedef struct packed {
        logic             req;
        logic [1:0]       mode;
        logic             load;
        logic [CNT_W-1:0] value;
    } pick_t;

    localparam logic [2:0]       WIN       = 3'(ROUNDS_TO_WIN);
    localparam logic [3:0]       HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_V    = CNT_W'(INIT_VALUE);

    state_e           state_q, state_d;
    logic [2:0]       go_sync_q, go_sync_d;
    logic [3:0]       who_sync_q, who_sync_d;
    logic [1:0]       who_cap_q, who_cap_d;
    pick_t            samp_a_q, samp_a_d;
    pick_t            samp_b_q, samp_b_d;
    logic             last_b_q, last_b_d;
    logic [3:0]       hold_q, hold_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic [1:0]       control_q, control_d;
    logic             init_q, init_d;
    logic [CNT_W-1:0] iv_q, iv_d;
    logic [2:0]       score_a_q, score_a_d;
    logic [2:0]       score_b_q, score_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       winner_q, winner_d;

    logic             go_rise;
    logic             win_a;
    logic             win_b;
    logic             time_up;
    logic [2:0]       inc_a;
    logic [2:0]       inc_b;

    assign go_rise = go_sync_q[1] & ~go_sync_q[2];
    assign inc_a   = (score_a_q == 3'd7) ? 3'd7 : score_a_q + 3'd1;
    assign inc_b   = (score_b_q == 3'd7) ? 3'd7 : score_b_q + 3'd1;

`ifdef MATCH_TIMEOUT_EN
    localparam int             TO_W    = $clog2(ROUND_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ROUND_TIMEOUT - 1);

    logic [TO_W-1:0] timer_q, timer_d;
    logic            tmo_q, tmo_d;

    assign time_up       = (timer_q == TO_LAST);
    assign timer_d       = (state_q == S_RUN) ? timer_q + TO_W'(1) : '0;
    assign timeout_pulse = tmo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            tmo_q   <= tmo_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign time_up            = 1'b0;
    assign unused_timeout_cfg = ROUND_TIMEOUT[0];
`endif

    always_comb begin
        state_d    = state_q;
        go_sync_d  = {go_sync_q[1:0], gameover};
        who_sync_d = {who_sync_q[1:0], who};
        who_cap_d  = who_cap_q;
        last_b_d   = last_b_q;
        hold_d     = hold_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        control_d  = control_q;
        init_d     = 1'b0;
        iv_d       = iv_q;
        score_a_d  = score_a_q;
        score_b_d  = score_b_q;
        winner_d   = winner_q;
        win_a      = 1'b0;
        win_b      = 1'b0;
`ifdef MATCH_TIMEOUT_EN
        tmo_d      = 1'b0;
`endif
        // requests only enter the grant pipeline while a round is live
        samp_a_d = '{req: req_a && (state_q == S_RUN), mode: mode_a,
                     load: load_a, value: value_a};
        samp_b_d = '{req: req_b && (state_q == S_RUN), mode: mode_b,
                     load: load_b, value: value_b};

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    score_a_d = 3'd0;
                    score_b_d = 3'd0;
                    winner_d  = 2'b00;
                end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                if (go_rise) begin
                    state_d   = S_SCORE;
                    who_cap_d = who_sync_q[3:2];
                end else if (time_up) begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LAST;
`ifdef MATCH_TIMEOUT_EN
                    tmo_d   = 1'b1;
`endif
                end else begin
                    win_a = samp_a_q.req && (!samp_b_q.req || last_b_q);
                    win_b = samp_b_q.req && !win_a;
                end
            end
            S_SCORE: begin
                state_d = S_HOLD;
                hold_d  = HOLD_LAST;
                if (who_cap_q == 2'b10) begin
                    score_a_d = inc_a;
                    if (inc_a >= WIN) begin
                        state_d  = S_DONE;
                        winner_d = 2'b01;
                    end
                end else if (who_cap_q == 2'b01) begin
                    score_b_d = inc_b;
                    if (inc_b >= WIN) begin
                        state_d  = S_DONE;
                        winner_d = 2'b10;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == 4'd0) state_d = S_LOAD;
                else hold_d = hold_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (win_a) begin
            gnt_a_d   = 1'b1;
            last_b_d  = 1'b0;
            control_d = samp_a_q.mode;
            if (samp_a_q.load) begin
                init_d = 1'b1;
                iv_d   = samp_a_q.value;
            end
        end
        if (win_b) begin
            gnt_b_d   = 1'b1;
            last_b_d  = 1'b1;
            control_d = samp_b_q.mode;
            if (samp_b_q.load) begin
                init_d = 1'b1;
                iv_d   = samp_b_q.value;
            end
        end
        if (state_d == S_LOAD) begin
            init_d = 1'b1;
            iv_d   = INIT_V;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN) ||
                 (state_d == S_SCORE) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    // last_b resets high so that A wins the first contested cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            go_sync_q  <= '0;
            who_sync_q <= '0;
            who_cap_q  <= '0;
            samp_a_q   <= '0;
            samp_b_q   <= '0;
            last_b_q   <= 1'b1;
            hold_q     <= '0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            control_q  <= '0;
            init_q     <= 1'b0;
            iv_q       <= '0;
            score_a_q  <= '0;
            score_b_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            winner_q   <= '0;
        end else begin
            state_q    <= state_d;
            go_sync_q  <= go_sync_d;
            who_sync_q <= who_sync_d;
            who_cap_q  <= who_cap_d;
            samp_a_q   <= samp_a_d;
            samp_b_q   <= samp_b_d;
            last_b_q   <= last_b_d;
            hold_q     <= hold_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            control_q  <= control_d;
            init_q     <= init_d;
            iv_q       <= iv_d;
            score_a_q  <= score_a_d;
            score_b_q  <= score_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            winner_q   <= winner_d;
        end
    end

    assign gnt_a         = gnt_a_q;
    assign gnt_b         = gnt_b_q;
    assign control       = control_q;
    assign init          = init_q;
    assign initial_value = iv_q;
    assign score_a       = score_a_q;
    assign score_b       = score_b_q;
    assign busy          = busy_q;
    assign match_done    = done_q;
    assign match_winner  = winner_q;

endmodule
